// File: rtl/drive_sequencer.sv
// Drivetrain sequencer: enable, obstacle hold with timed resume, lost-line pivot search and fault latch.
// Build option DRIVE_SEQ_RAMP_EN: soft-start duty ramping; otherwise duty follows its target on the next cycle.
module drive_sequencer #(
    parameter int TICK_DIV     = 100000,
    parameter int DUTY_MAX     = 850,
    parameter int SEARCH_DUTY  = 600,
    parameter int RAMP_STEP    = 50,
    parameter int LOST_TICKS   = 500,
    parameter int RESUME_TICKS = 200,
    parameter int SWEEP_TICKS  = 300,
    parameter int MAX_SWEEPS   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] track_dir,
    input  logic       obstacle,
    output logic [9:0] left_duty,
    output logic [9:0] right_duty,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic [2:0] seq_state,
    output logic       fault
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        HOLD   = 3'd2,
        SEARCH = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [1:0] DIR_OFF  = 2'b00;
    localparam logic [1:0] DIR_FWD  = 2'b10;
    localparam logic [1:0] DIR_BACK = 2'b01;
    localparam logic [1:0] TRK_LEFT  = 2'd1;
    localparam logic [1:0] TRK_RIGHT = 2'd2;
    localparam logic [1:0] TRK_LOST  = 2'd3;

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int LW = $clog2(LOST_TICKS + 1);
    localparam int RW = $clog2(RESUME_TICKS + 1);
    localparam int SW = $clog2(SWEEP_TICKS + 1);
    localparam int CW = $clog2(MAX_SWEEPS + 1);
    localparam logic [9:0] RUN_DUTY = 10'(DUTY_MAX);
    localparam logic [9:0] PIV_DUTY = 10'(SEARCH_DUTY);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [LW-1:0] lost_q, lost_d;
    logic [RW-1:0] resume_q, resume_d;
    logic [SW-1:0] sweep_tmr_q, sweep_tmr_d;
    logic [CW-1:0] sweep_cnt_q, sweep_cnt_d;
    logic          pivot_right_q, pivot_right_d;
    logic          last_right_q, last_right_d;
    logic [1:0]    run_sel_q, run_sel_d;
    logic [9:0]    left_duty_q, left_duty_d, right_duty_q, right_duty_d;
    logic [1:0]    left_dir_q, left_dir_d, right_dir_q, right_dir_d;
    logic          fault_q, fault_d;
    logic          tick;
    logic [1:0]    run_sel;
    logic [9:0]    l_tgt, r_tgt;
    logic          reverse;

`ifdef DRIVE_SEQ_RAMP_EN
    // Rises by at most RAMP_STEP per tick; any decrease lands on the target at once.
    function automatic logic [9:0] ramp_duty(input logic [9:0] cur, input logic [9:0] tgt,
                                             input logic step);
        logic [10:0] sum;
        sum = {1'b0, cur} + 11'(RAMP_STEP);
        if (cur >= tgt)             ramp_duty = tgt;
        else if (!step)             ramp_duty = cur;
        else if (sum >= {1'b0, tgt}) ramp_duty = tgt;
        else                        ramp_duty = sum[9:0];
    endfunction
`endif

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        lost_d        = '0;
        resume_d      = '0;
        sweep_tmr_d   = '0;
        sweep_cnt_d   = '0;
        pivot_right_d = pivot_right_q;
        run_sel_d     = (track_dir != TRK_LOST) ? track_dir : run_sel_q;
        last_right_d  = (track_dir == TRK_RIGHT) ? 1'b1 :
                        (track_dir == TRK_LEFT)  ? 1'b0 : last_right_q;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (obstacle) begin
                        state_d = HOLD;
                    end else if (track_dir == TRK_LOST) begin
                        lost_d = lost_q;
                        if (tick) begin
                            if (lost_q == LW'(LOST_TICKS - 1)) begin
                                state_d       = SEARCH;
                                lost_d        = '0;
                                pivot_right_d = last_right_q;
                            end else begin
                                lost_d = lost_q + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!obstacle) begin
                        resume_d = resume_q;
                        if (tick) begin
                            if (resume_q == RW'(RESUME_TICKS - 1)) begin
                                state_d  = RUN;
                                resume_d = '0;
                            end else begin
                                resume_d = resume_q + 1'b1;
                            end
                        end
                    end
                end
                SEARCH: begin
                    if (obstacle) begin
                        state_d = HOLD;
                    end else if (track_dir != TRK_LOST) begin
                        state_d = RUN;
                    end else begin
                        sweep_tmr_d = sweep_tmr_q;
                        sweep_cnt_d = sweep_cnt_q;
                        if (tick) begin
                            if (sweep_tmr_q == SW'(SWEEP_TICKS - 1)) begin
                                sweep_tmr_d = '0;
                                if (sweep_cnt_q == CW'(MAX_SWEEPS - 1)) begin
                                    state_d     = FAULT;
                                    sweep_cnt_d = '0;
                                end else begin
                                    sweep_cnt_d   = sweep_cnt_q + 1'b1;
                                    pivot_right_d = ~pivot_right_q;
                                end
                            end else begin
                                sweep_tmr_d = sweep_tmr_q + 1'b1;
                            end
                        end
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end

        // Outputs follow the state being entered so duty, dir and seq_state stay aligned.
        l_tgt      = '0;
        r_tgt      = '0;
        left_dir_d  = DIR_OFF;
        right_dir_d = DIR_OFF;
        run_sel    = (track_dir == TRK_LOST) ? run_sel_q : track_dir;
        case (state_d)
            RUN: begin
                case (run_sel)
                    TRK_LEFT:  begin r_tgt = RUN_DUTY; right_dir_d = DIR_FWD; end
                    TRK_RIGHT: begin l_tgt = RUN_DUTY; left_dir_d  = DIR_FWD; end
                    default: begin
                        l_tgt = RUN_DUTY; r_tgt = RUN_DUTY;
                        left_dir_d = DIR_FWD; right_dir_d = DIR_FWD;
                    end
                endcase
            end
            SEARCH: begin
                l_tgt = PIV_DUTY;
                r_tgt = PIV_DUTY;
                left_dir_d  = pivot_right_d ? DIR_FWD  : DIR_BACK;
                right_dir_d = pivot_right_d ? DIR_BACK : DIR_FWD;
            end
            default: ;
        endcase

        // A wheel reversing fwd<->back gets one zero-duty cycle on both wheels (no shoot-through).
        reverse = ((left_dir_d != DIR_OFF) && (left_dir_q != DIR_OFF) && (left_dir_d != left_dir_q)) ||
                  ((right_dir_d != DIR_OFF) && (right_dir_q != DIR_OFF) && (right_dir_d != right_dir_q));
`ifdef DRIVE_SEQ_RAMP_EN
        left_duty_d  = reverse ? '0 : ramp_duty(left_duty_q, l_tgt, tick);
        right_duty_d = reverse ? '0 : ramp_duty(right_duty_q, r_tgt, tick);
`else
        left_duty_d  = reverse ? '0 : l_tgt;
        right_duty_d = reverse ? '0 : r_tgt;
`endif
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            lost_q        <= '0;
            resume_q      <= '0;
            sweep_tmr_q   <= '0;
            sweep_cnt_q   <= '0;
            pivot_right_q <= 1'b0;
            last_right_q  <= 1'b0;
            run_sel_q     <= '0;
            left_duty_q   <= '0;
            right_duty_q  <= '0;
            left_dir_q    <= DIR_OFF;
            right_dir_q   <= DIR_OFF;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            lost_q        <= lost_d;
            resume_q      <= resume_d;
            sweep_tmr_q   <= sweep_tmr_d;
            sweep_cnt_q   <= sweep_cnt_d;
            pivot_right_q <= pivot_right_d;
            last_right_q  <= last_right_d;
            run_sel_q     <= run_sel_d;
            left_duty_q   <= left_duty_d;
            right_duty_q  <= right_duty_d;
            left_dir_q    <= left_dir_d;
            right_dir_q   <= right_dir_d;
            fault_q       <= fault_d;
        end
    end

    assign left_duty  = left_duty_q;
    assign right_duty = right_duty_q;
    assign left_dir   = left_dir_q;
    assign right_dir  = right_dir_q;
    assign seq_state  = state_q;
    assign fault      = fault_q;
endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: per-cycle compare against a tick-level behavioural model plus directed literal checks.
module tb_drive_sequencer;
    localparam int TICK_DIV     = 4;
    localparam int DUTY_MAX     = 850;
    localparam int SEARCH_DUTY  = 600;
    localparam int RAMP_STEP    = 100;
    localparam int LOST_TICKS   = 5;
    localparam int RESUME_TICKS = 3;
    localparam int SWEEP_TICKS  = 4;
    localparam int MAX_SWEEPS   = 2;
    localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_SEARCH = 3, S_FAULT = 4;
    localparam int FWD = 2, BACK = 1, OFF = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] track_dir = 2'd0;
    logic       obstacle = 1'b0;
    logic [9:0] left_duty, right_duty;
    logic [1:0] left_dir, right_dir;
    logic [2:0] seq_state;
    logic       fault;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    drive_sequencer #(
        .TICK_DIV(TICK_DIV), .DUTY_MAX(DUTY_MAX), .SEARCH_DUTY(SEARCH_DUTY),
        .RAMP_STEP(RAMP_STEP), .LOST_TICKS(LOST_TICKS), .RESUME_TICKS(RESUME_TICKS),
        .SWEEP_TICKS(SWEEP_TICKS), .MAX_SWEEPS(MAX_SWEEPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .track_dir(track_dir),
        .obstacle(obstacle), .left_duty(left_duty), .right_duty(right_duty),
        .left_dir(left_dir), .right_dir(right_dir), .seq_state(seq_state), .fault(fault)
    );

    always #5 clk = ~clk;

    // Behavioural model: tick-counted timers and wheel targets, updated once per rising edge.
    int m_mode = S_IDLE, m_edge = 0, m_lost = 0, m_resume = 0, m_sweep_t = 0, m_sweeps = 0;
    int m_ld = 0, m_rd = 0, m_ldir = OFF, m_rdir = OFF, m_fault = 0, m_run_sel = 0;
    bit m_turn_right = 1'b0, m_pivot_right = 1'b0;

    task automatic model_reset();
        m_mode = S_IDLE; m_edge = 0; m_lost = 0; m_resume = 0; m_sweep_t = 0; m_sweeps = 0;
        m_ld = 0; m_rd = 0; m_ldir = OFF; m_rdir = OFF; m_fault = 0; m_run_sel = 0;
        m_turn_right = 1'b0; m_pivot_right = 1'b0;
    endtask

    task automatic model_step();
        bit tk;
        int nxt, sel, tl, tr, dl, dr;
        bit rev;
        tk = ((m_edge % TICK_DIV) == TICK_DIV - 1);
        m_edge++;
        nxt = m_mode;
        if (!enable) nxt = S_IDLE;
        else if (m_mode == S_IDLE) nxt = S_RUN;
        else if ((m_mode == S_RUN || m_mode == S_SEARCH) && obstacle) nxt = S_HOLD;
        else if (m_mode == S_RUN && track_dir == 3 && tk) begin
            m_lost++;
            if (m_lost == LOST_TICKS) begin nxt = S_SEARCH; m_pivot_right = m_turn_right; end
        end else if (m_mode == S_HOLD && !obstacle && tk) begin
            m_resume++;
            if (m_resume == RESUME_TICKS) nxt = S_RUN;
        end else if (m_mode == S_SEARCH && track_dir != 3) nxt = S_RUN;
        else if (m_mode == S_SEARCH && tk) begin
            m_sweep_t++;
            if (m_sweep_t == SWEEP_TICKS) begin
                m_sweep_t = 0;
                m_sweeps++;
                if (m_sweeps == MAX_SWEEPS) nxt = S_FAULT;
                else m_pivot_right = !m_pivot_right;
            end
        end
        if (!(m_mode == S_RUN && nxt == S_RUN && track_dir == 3)) m_lost = 0;
        if (!(m_mode == S_HOLD && nxt == S_HOLD && !obstacle)) m_resume = 0;
        if (!(m_mode == S_SEARCH && nxt == S_SEARCH)) begin m_sweep_t = 0; m_sweeps = 0; end

        tl = 0; tr = 0; dl = OFF; dr = OFF;
        sel = (track_dir == 3) ? m_run_sel : int'(track_dir);
        if (nxt == S_RUN) begin
            if (sel != 1) begin tl = DUTY_MAX; dl = FWD; end
            if (sel != 2) begin tr = DUTY_MAX; dr = FWD; end
        end else if (nxt == S_SEARCH) begin
            tl = SEARCH_DUTY; tr = SEARCH_DUTY;
            dl = m_pivot_right ? FWD : BACK;
            dr = m_pivot_right ? BACK : FWD;
        end
        rev = (dl != OFF && m_ldir != OFF && dl != m_ldir) || (dr != OFF && m_rdir != OFF && dr != m_rdir);
`ifdef DRIVE_SEQ_RAMP_EN
        m_ld = rev ? 0 : (m_ld > tl) ? tl : (tk ? ((m_ld + RAMP_STEP > tl) ? tl : m_ld + RAMP_STEP) : m_ld);
        m_rd = rev ? 0 : (m_rd > tr) ? tr : (tk ? ((m_rd + RAMP_STEP > tr) ? tr : m_rd + RAMP_STEP) : m_rd);
`else
        m_ld = rev ? 0 : tl;
        m_rd = rev ? 0 : tr;
`endif
        m_ldir = dl; m_rdir = dr;
        m_fault = (nxt == S_FAULT) ? 1 : 0;
        m_mode = nxt;
        if (track_dir == 2) m_turn_right = 1'b1;
        else if (track_dir == 1) m_turn_right = 1'b0;
        if (track_dir != 3) m_run_sel = int'(track_dir);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Scoreboard compare, every falling edge once checking is armed.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if ({left_duty, right_duty, left_dir, right_dir, seq_state, fault} !==
                {10'(m_ld), 10'(m_rd), 2'(m_ldir), 2'(m_rdir), 3'(m_mode), 1'(m_fault)}) begin
                errors++;
                $display("FAIL model_cycle t=%0t: got ld=%0d rd=%0d ldir=%b rdir=%b st=%0d f=%b, expected ld=%0d rd=%0d ldir=%0d rdir=%0d st=%0d f=%0d",
                         $time, left_duty, right_duty, left_dir, right_dir, seq_state, fault,
                         m_ld, m_rd, m_ldir, m_rdir, m_mode, m_fault);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int n = 0;
        while (int'(seq_state) != s && n < budget) begin @(negedge clk); n++; end
        check(nm, 32'(seq_state), 32'(s));
    endtask

    task automatic wait_ldir(input int d, input int budget, input string nm);
        int n = 0;
        while (int'(left_dir) != d && n < budget) begin @(negedge clk); n++; end
        check(nm, 32'(left_dir), 32'(d));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        step(3);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_left_duty", 32'(left_duty), 0);
        check("rst_right_dir", 32'(right_dir), 0);
        check("rst_state", 32'(seq_state), S_IDLE);
        check("rst_fault", 32'(fault), 0);

        // Straight run: soft start (or immediate) to 850 on both wheels.
        enable = 1'b1; track_dir = 2'd0;
        step(1);
        check("enter_run", 32'(seq_state), S_RUN);
`ifndef DRIVE_SEQ_RAMP_EN
        check("noramp_first_duty", 32'(left_duty), 850);
`endif
        step(45);
        check("run_left_850", 32'(left_duty), 850);
        check("run_right_850", 32'(right_duty), 850);
        check("run_dirs_fwd", 32'({left_dir, right_dir}), 32'h0A);

        // Left turn: inner wheel drops to 0/off at once.
        track_dir = 2'd1;
        step(1);
        check("turn_left_duty", 32'(left_duty), 0);
        check("turn_left_dir", 32'(left_dir), OFF);
        check("turn_right_duty", 32'(right_duty), 850);

        // Obstacle hold, resume counter cleared by obstacle, then timed resume.
        obstacle = 1'b1;
        step(1);
        check("hold_enter", 32'(seq_state), S_HOLD);
        check("hold_right_zero", 32'(right_duty), 0);
        obstacle = 1'b0; step(8);
        check("hold_after_2_ticks", 32'(seq_state), S_HOLD);
        obstacle = 1'b1; step(4);
        check("hold_obstacle_again", 32'(seq_state), S_HOLD);
        obstacle = 1'b0; step(8);
        check("hold_counter_cleared", 32'(seq_state), S_HOLD);
        step(4);
        check("resume_run", 32'(seq_state), S_RUN);
`ifndef DRIVE_SEQ_RAMP_EN
        check("resume_right_duty", 32'(right_duty), 850);
`endif

        // Right turn, then lost line: search pivots right, flips, then faults.
        track_dir = 2'd2;
        step(50);
        check("right_turn_left_duty", 32'(left_duty), 850);
        check("right_turn_right_dir", 32'(right_dir), OFF);
        track_dir = 2'd3;
        wait_state(S_SEARCH, 30, "lost_to_search");
        check("pivot_left_fwd", 32'(left_dir), FWD);
        check("pivot_right_back", 32'(right_dir), BACK);
        check("pivot_left_duty", 32'(left_duty), 600);
`ifndef DRIVE_SEQ_RAMP_EN
        check("pivot_right_duty", 32'(right_duty), 600);
`endif
        wait_ldir(BACK, 30, "flip_left_back");
        check("flip_zero_left", 32'(left_duty), 0);
        check("flip_zero_right", 32'(right_duty), 0);
        check("flip_right_fwd", 32'(right_dir), FWD);
        wait_state(S_FAULT, 40, "search_to_fault");
        check("fault_flag", 32'(fault), 1);
        check("fault_dirs_off", 32'({left_dir, right_dir}), 0);
        obstacle = 1'b1; step(3);
        check("fault_ignores_obstacle", 32'(seq_state), S_FAULT);
        obstacle = 1'b0;
        enable = 1'b0; step(1);
        check("disable_idle", 32'(seq_state), S_IDLE);
        check("disable_fault_clear", 32'(fault), 0);

        // Recovery out of search clears the sweep count.
        enable = 1'b1;
        wait_state(S_SEARCH, 40, "relost_search");
        wait_ldir(BACK, 30, "recover_flip");
        track_dir = 2'd0; step(1);
        check("search_recover_run", 32'(seq_state), S_RUN);
        track_dir = 2'd3;
        wait_state(S_SEARCH, 40, "search_again");
        wait_ldir(BACK, 30, "second_search_flip");
        step(1);
        check("sweeps_cleared", 32'(seq_state), S_SEARCH);
        obstacle = 1'b1; step(1);
        check("search_obstacle_hold", 32'(seq_state), S_HOLD);
        obstacle = 1'b0;
        wait_state(S_RUN, 20, "hold_resume_lost");

        // Obstacle lands on the same edge as lost-timer expiry: hold wins.
        n = 0;
        while (!(m_mode == S_RUN && m_lost == LOST_TICKS - 1 && (m_edge % TICK_DIV) == TICK_DIV - 1) && n < 60) begin
            @(negedge clk); n++;
        end
        obstacle = 1'b1; step(1);
        check("simul_hold_wins", 32'(seq_state), S_HOLD);
        obstacle = 1'b0;
        wait_state(S_RUN, 20, "simul_resume");
        step(6);
        check("lost_counter_cleared", 32'(seq_state), S_RUN);

        // Asynchronous reset mid-run.
        track_dir = 2'd0; step(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_left_duty", 32'(left_duty), 0);
        check("async_rst_right_duty", 32'(right_duty), 0);
        check("async_rst_dirs", 32'({left_dir, right_dir}), 0);
        check("async_rst_fault", 32'(fault), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_idle", 32'(seq_state), S_IDLE);
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
